// File: rtl/pcm_to_pdm_pkg.sv
// Shared types and constants for the PCM-to-PDM transmit path.
// LFSR constants are only consumed when PCM_TO_PDM_DITHER_EN is defined.
package pcm_to_pdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcm_to_pdm_sd_mod_ch.sv
// One channel of the first-order sigma-delta modulator: an accumulator whose
// carry-out is the PDM bit. The residue carries across sample boundaries.
module sd_mod_ch #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_strobe,
  input  logic [BIT_WIDTH-1:0] i_sample,
  input  logic                 i_cin,
  output logic                 o_bit
);

  logic [BIT_WIDTH:0] r_acc;
  logic [BIT_WIDTH:0] w_sum;

  assign w_sum = {1'b0, r_acc[BIT_WIDTH-1:0]} + {1'b0, i_sample}
               + {{BIT_WIDTH{1'b0}}, i_cin};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_strobe) begin
      r_acc <= w_sum;
    end
  end

  // The registered carry-out only moves on a strobe, so it is the output bit
  assign o_bit = r_acc[BIT_WIDTH];

endmodule

// File: rtl/pcm_to_pdm.sv
// PCM-to-PDM converter: pdm_clk divider, one-entry sample buffer, IDLE/RUN
// sequencing and NUM_CHANNELS modulators. Define PCM_TO_PDM_DITHER_EN for LFSR dither.
module pcm_to_pdm
  import pcm_to_pdm_pkg::*;
#(
  parameter int BIT_WIDTH          = 8,
  parameter int NUM_CHANNELS       = 9,
  parameter int PDM_CLK_DEC_FACTOR = 12,
  parameter int OSR                = 128
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CHANNELS*BIT_WIDTH-1:0] pcm_data,
  input  logic                              pcm_valid,
  output logic                              pcm_ready,
  output logic                              pdm_clk,
  output logic [NUM_CHANNELS-1:0]           pdm_out,
  output logic                              sample_tick,
  output logic                              underrun
);

  localparam int DIV_W = cnt_width(PDM_CLK_DEC_FACTOR);
  localparam int BIT_W = cnt_width(OSR);

  logic [DIV_W-1:0]                  r_div;
  logic                              r_pdm_clk;
  logic [BIT_W-1:0]                  r_bitcnt;
  state_t                            r_state;
  state_t                            w_state_nxt;
  logic                              r_pend_valid;
  logic                              r_ready;
  logic [NUM_CHANNELS*BIT_WIDTH-1:0] r_pend_data;
  logic [NUM_CHANNELS*BIT_WIDTH-1:0] r_cur;
  logic                              r_tick;
  logic                              r_underrun;

  logic                              w_wrap;
  logic                              w_strobe;
  logic                              w_last;
  logic                              w_accept;
  logic                              w_load;
  logic                              w_underrun;
  logic                              w_mod_en;
  logic                              w_cin;
  logic [NUM_CHANNELS*BIT_WIDTH-1:0] w_sample_src;

  assign w_wrap   = (r_div == DIV_W'(PDM_CLK_DEC_FACTOR - 1));
  assign w_strobe = w_wrap & r_pdm_clk;
  assign w_last   = (r_bitcnt == BIT_W'(OSR - 1));
  assign w_accept = pcm_valid & r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_pdm_clk <= 1'b0;
    end else begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
      if (w_wrap) r_pdm_clk <= ~r_pdm_clk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE && w_strobe && r_pend_valid) w_state_nxt = RUN;
  end

  // A load strobe also emits the first bit of the new sample
  always_comb begin
    w_load     = 1'b0;
    w_underrun = 1'b0;
    w_mod_en   = 1'b0;
    case (r_state)
      IDLE: begin
        w_load   = w_strobe & r_pend_valid;
        w_mod_en = w_strobe & r_pend_valid;
      end
      RUN: begin
        w_load     = w_strobe & w_last & r_pend_valid;
        w_underrun = w_strobe & w_last & ~r_pend_valid;
        w_mod_en   = w_strobe;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt     <= '0;
      r_pend_valid <= 1'b0;
      r_ready      <= 1'b1;
      r_pend_data  <= '0;
      r_cur        <= '0;
      r_tick       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      if (r_state == RUN && w_strobe) r_bitcnt <= r_bitcnt + 1'b1;
      if (w_accept) begin
        r_pend_valid <= 1'b1;
        r_ready      <= 1'b0;
        r_pend_data  <= pcm_data;
      end else if (w_load) begin
        r_pend_valid <= 1'b0;
        r_ready      <= 1'b1;
      end
      if (w_load) r_cur <= r_pend_data;
      r_tick     <= w_load;
      r_underrun <= w_underrun;
    end
  end

  assign w_sample_src = w_load ? r_pend_data : r_cur;

`ifdef PCM_TO_PDM_DITHER_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_lfsr <= LFSR_SEED;
    else if (w_strobe) r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign w_cin = r_lfsr[0];
`else
  assign w_cin = 1'b0;
`endif

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    sd_mod_ch #(.BIT_WIDTH(BIT_WIDTH)) u_ch (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_strobe (w_mod_en),
      .i_sample (w_sample_src[k*BIT_WIDTH +: BIT_WIDTH]),
      .i_cin    (w_cin),
      .o_bit    (pdm_out[k])
    );
  end

  assign pcm_ready   = r_ready;
  assign pdm_clk     = r_pdm_clk;
  assign sample_tick = r_tick;
  assign underrun    = r_underrun;

endmodule

// File: tb/tb_pcm_to_pdm.sv
// Self-checking bench for pcm_to_pdm: table of sample sets with expected
// per-window ones counts, scoreboard queue, and hand-written corner sequences.
module tb_pcm_to_pdm;

  localparam int BW   = 8;
  localparam int NCH  = 9;
  localparam int DEC  = 12;
  localparam int OSR  = 128;

  logic                clk;
  logic                rst_n;
  logic [NCH*BW-1:0]   pcm_data;
  logic                pcm_valid;
  logic                pcm_ready;
  logic                pdm_clk;
  logic [NCH-1:0]      pdm_out;
  logic                sample_tick;
  logic                underrun;

  pcm_to_pdm #(
    .BIT_WIDTH(BW), .NUM_CHANNELS(NCH), .PDM_CLK_DEC_FACTOR(DEC), .OSR(OSR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pcm_data(pcm_data), .pcm_valid(pcm_valid),
    .pcm_ready(pcm_ready), .pdm_clk(pdm_clk), .pdm_out(pdm_out),
    .sample_tick(sample_tick), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NCH*BW-1:0] data;
    logic [NCH*BW-1:0] expd;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  int       exp_q[$];
  int       cur_exp[NCH];
  int       ones[NCH];
  int       nbits = 0;
  bit       in_win = 1'b0;
  int       bad_changes = 0;
  int       n_tick = 0;
  int       n_under = 0;
  logic [3:0] first_bits;
  logic [3:0] first4_log[$];
  logic       prev_clk = 1'b0;
  logic [NCH-1:0] prev_out = '0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic close_window();
    check("window_bits", nbits, OSR);
    check("window_no_offstrobe_change", bad_changes, 0);
    for (int k = 0; k < NCH; k++) check($sformatf("ones_ch%0d", k), ones[k], cur_exp[k]);
    first4_log.push_back(first_bits);
  endtask

  // Monitor: windows start at each sample_tick/underrun strobe
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      in_win   = 1'b0;
      prev_clk = 1'b0;
      prev_out = '0;
    end else begin
      if (prev_clk && !pdm_clk) begin
        if (sample_tick || underrun) begin
          check("tick_underrun_exclusive", int'(sample_tick && underrun), 0);
          if (in_win) close_window();
          if (sample_tick) begin
            n_tick++;
            if (exp_q.size() < NCH) begin
              check("scoreboard_nonempty", exp_q.size(), NCH);
              for (int k = 0; k < NCH; k++) cur_exp[k] = -1;
            end else begin
              for (int k = 0; k < NCH; k++) cur_exp[k] = exp_q.pop_front();
            end
          end
          if (underrun) n_under++;
          in_win = 1'b1;
          nbits = 0;
          bad_changes = 0;
          first_bits = '0;
          for (int k = 0; k < NCH; k++) ones[k] = 0;
        end
        if (in_win) begin
          for (int k = 0; k < NCH; k++) ones[k] += int'(pdm_out[k]);
          if (nbits < 4) first_bits[nbits] = pdm_out[0];
          nbits++;
        end
      end else if (pdm_out !== prev_out) begin
        bad_changes++;
      end
      prev_clk = pdm_clk;
      prev_out = pdm_out;
    end
  end

  function automatic logic [NCH*BW-1:0] uni(input logic [BW-1:0] v);
    logic [NCH*BW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*BW +: BW] = v;
    return r;
  endfunction

  task automatic send_set(input logic [NCH*BW-1:0] d, input logic [NCH*BW-1:0] e);
    int t = 0;
    @(negedge clk);
    pcm_data  = d;
    pcm_valid = 1'b1;
    while (!pcm_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!pcm_ready) begin
      check("send_timeout", 1, 0);
      pcm_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 0; k < NCH; k++) exp_q.push_back(int'(e[k*BW +: BW]));
    #1;
    pcm_valid = 1'b0;
    check("ready_drops_after_accept", int'(pcm_ready), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pdm_clk"}, int'(pdm_clk), 0);
    check({tag, "_pdm_out"}, int'(pdm_out), 0);
    check({tag, "_pcm_ready"}, int'(pcm_ready), 1);
    check({tag, "_sample_tick"}, int'(sample_tick), 0);
    check({tag, "_underrun"}, int'(underrun), 0);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    int cnt;
    int base;
    int viol;

    // Expected ones per 128-bit window: even s gives exactly s/2 regardless of residue
    v.data = uni(8'h80); v.expd = uni(8'd64); tbl.push_back(v);
    v.data = uni(8'h00); v.expd = uni(8'd0);  tbl.push_back(v);
    v.data = uni(8'h60); v.expd = uni(8'd48); tbl.push_back(v);
    v.data = uni(8'hC0); v.expd = uni(8'd96); tbl.push_back(v);
    v.data = uni(8'h20); v.expd = uni(8'd16); tbl.push_back(v);
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < NCH; k++) begin
        v.data[k*BW +: BW] = BW'(16 * k + 2 * j);
        v.expd[k*BW +: BW] = BW'(8 * k + j);
      end
      tbl.push_back(v);
    end
    v.data = uni(8'h40); v.expd = uni(8'd32); tbl.push_back(v);

    rst_n     = 1'b0;
    pcm_valid = 1'b0;
    pcm_data  = '0;
    #23;
    check_reset_outputs("reset");

    // Divider: first rise 12 clks after release, then toggles every 12
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      logic lvl;
      lvl = pdm_clk;
      cnt = 0;
      do begin
        @(posedge clk);
        #1;
        cnt++;
      end while (pdm_clk == lvl && cnt < 100);
      check($sformatf("div_half_period_%0d", p), cnt, DEC);
    end

    foreach (tbl[i]) send_set(tbl[i].data, tbl[i].expd);

    // Underrun: last set retained, windows keep density
    base = n_tick;
    cnt = n_under;
    for (int t = 0; t < 20000 && n_under < cnt + 3; t++) @(posedge clk);
    check("underrun_pulses", (n_under >= cnt + 3) ? 1 : 0, 1);
    check("no_tick_during_underrun", n_tick - base, 1);

    // Reset mid-window with pending full
    cnt = 0;
    while (nbits != 50 && cnt < 5000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("reached_bit50", nbits, 50);
    send_set(uni(8'h10), uni(8'd8));
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base = n_tick;
    viol = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (pdm_out !== '0) viol++;
    end
    check("idle_pdm_out_zero", viol, 0);
    check("idle_no_tick", n_tick - base, 0);

    // Fresh accumulator with 0xFF: 127 then 128 ones -> 255 in first 256 bits
    send_set(uni(8'hFF), uni(8'd127));
    send_set(uni(8'hFF), uni(8'd128));
    send_set(uni(8'h00), uni(8'd0));
    cnt = n_under;
    for (int t = 0; t < 8000 && n_under < cnt + 1; t++) @(posedge clk);
    check("final_window_closed", (n_under >= cnt + 1) ? 1 : 0, 1);

    if (first4_log.size() > 0) check("ch0_pattern_0x80", int'(first4_log[0]), 4'b1010);
    else check("ch0_pattern_logged", 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
